// File: rtl/sequencer_pkg.sv
// ==== sequencer_pkg : shared step-sequencer modes, player states and helpers (rev 1.0) ====
`default_nettype none

package sequencer_pkg;

   localparam logic [1:0] MODE_EDIT = 2'd0;
   localparam logic [1:0] MODE_PLAY = 2'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRE   = 2'd1,
      WAIT   = 2'd2,
      PAUSED = 2'd3
   } player_state_t;

   typedef logic [2:0] step_idx_t;

   // A tempo of zero would never expire, so it plays as one tick per step.
   function automatic logic [7:0] eff_tempo(input logic [7:0] tempo);
      return (tempo == 8'd0) ? 8'd1 : tempo;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tempo_divider.sv
// ==== tempo_divider : prescaler plus tick counter, pulses step_done at step expiry (rev 1.0) ====
`default_nettype none

module tempo_divider #(
   parameter int TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] tempo_eff,
   output logic       step_done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   // The FIRE cycle is cycle 0 of the step, so expiry lands one count early.
   localparam logic [PW-1:0] PRESC_DONE = PW'(TICK_DIV - 2);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    tick_q, tick_d;

   always_comb begin
      presc_d = presc_q;
      tick_d  = tick_q;
      if (clear) begin
         presc_d = '0;
         tick_d  = '0;
      end else if (enable) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = tick_q + 8'd1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= '0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign step_done = enable && !clear &&
                      (presc_q == PRESC_DONE) &&
                      (tick_q == (tempo_eff - 8'd1));

endmodule

`default_nettype wire

// File: rtl/sequence_player.sv
// ==== sequence_player : play-mode step walker with triggers, gates and step index (rev 1.0) ====
`default_nettype none

module sequence_player
   import sequencer_pkg::*;
#(
   parameter int TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic [7:0] tempo,
   input  logic       pause,
   input  logic [3:0] seq_smpl_1,
   input  logic [3:0] seq_smpl_2,
   input  logic [3:0] seq_smpl_3,
   input  logic [3:0] seq_smpl_4,
   input  logic [3:0] seq_smpl_5,
   input  logic [3:0] seq_smpl_6,
   input  logic [3:0] seq_smpl_7,
   input  logic [3:0] seq_smpl_8,
   output logic [2:0] play_idx,
   output logic [3:0] play_smpl,
   output logic [3:0] play_gate,
   output logic       step_strobe
);

   player_state_t state_q, state_d;
   step_idx_t     play_idx_q, play_idx_d;
   logic [3:0]    play_smpl_q, play_smpl_d;
   logic [3:0]    play_gate_q, play_gate_d;
   logic          step_strobe_q, step_strobe_d;
   logic [7:0]    tempo_eff_q, tempo_eff_d;

   logic          div_clear;
   logic          div_enable;
   logic          step_done;
   logic [3:0]    cur_pattern;

   always_comb begin
      cur_pattern = 4'h0;
      case (play_idx_q)
         3'd0:    cur_pattern = seq_smpl_1;
         3'd1:    cur_pattern = seq_smpl_2;
         3'd2:    cur_pattern = seq_smpl_3;
         3'd3:    cur_pattern = seq_smpl_4;
         3'd4:    cur_pattern = seq_smpl_5;
         3'd5:    cur_pattern = seq_smpl_6;
         3'd6:    cur_pattern = seq_smpl_7;
         default: cur_pattern = seq_smpl_8;
      endcase
   end

   tempo_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tempo_divider (
      .clk       (clk),
      .rst       (rst),
      .clear     (div_clear),
      .enable    (div_enable),
      .tempo_eff (tempo_eff_q),
      .step_done (step_done)
   );

   always_comb begin
      state_d       = state_q;
      play_idx_d    = play_idx_q;
      play_smpl_d   = 4'h0;
      play_gate_d   = play_gate_q;
      step_strobe_d = 1'b0;
      tempo_eff_d   = tempo_eff_q;
      div_clear     = 1'b0;
      div_enable    = 1'b0;

      // Leaving play mode outranks pause and step expiry.
      if (mode != MODE_PLAY) begin
         state_d     = IDLE;
         play_idx_d  = '0;
         play_gate_d = 4'h0;
         tempo_eff_d = 8'd0;
         div_clear   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = FIRE;
               play_idx_d = '0;
               div_clear  = 1'b1;
            end
            FIRE: begin
               play_smpl_d   = cur_pattern;
               play_gate_d   = cur_pattern;
               step_strobe_d = 1'b1;
               tempo_eff_d   = eff_tempo(tempo);
               div_clear     = 1'b1;
               state_d       = WAIT;
            end
            WAIT: begin
               div_enable = 1'b1;
               if (step_done) begin
                  play_idx_d = play_idx_q + 3'd1;
                  state_d    = FIRE;
               end else if (pause) begin
                  state_d = PAUSED;
               end
            end
            PAUSED: begin
               if (!pause) begin
                  state_d = WAIT;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         play_idx_q    <= '0;
         play_smpl_q   <= 4'h0;
         play_gate_q   <= 4'h0;
         step_strobe_q <= 1'b0;
         tempo_eff_q   <= 8'd0;
      end else begin
         state_q       <= state_d;
         play_idx_q    <= play_idx_d;
         play_smpl_q   <= play_smpl_d;
         play_gate_q   <= play_gate_d;
         step_strobe_q <= step_strobe_d;
         tempo_eff_q   <= tempo_eff_d;
      end
   end

   assign play_idx    = play_idx_q;
   assign play_smpl   = play_smpl_q;
   assign play_gate   = play_gate_q;
   assign step_strobe = step_strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_sequence_player.sv
// ==== tb_sequence_player : scoreboard bench for sequence_player at TICK_DIV=4 (rev 1.0) ====
`default_nettype none

module tb_sequence_player;
   import sequencer_pkg::*;

   localparam int TICK_DIV = 4;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic [1:0] mode  = 2'd0;
   logic [7:0] tempo = 8'd0;
   logic       pause = 1'b0;
   logic [3:0] pat [8];
   logic [3:0] ref_pat [8];

   logic [2:0] play_idx;
   logic [3:0] play_smpl;
   logic [3:0] play_gate;
   logic       step_strobe;

   typedef struct {
      logic [2:0] idx;
      logic [3:0] smpl;
      int         period;
   } exp_t;

   exp_t exp_q [$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   last_cyc = -1;

   sequence_player #(
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .tempo       (tempo),
      .pause       (pause),
      .seq_smpl_1  (pat[0]),
      .seq_smpl_2  (pat[1]),
      .seq_smpl_3  (pat[2]),
      .seq_smpl_4  (pat[3]),
      .seq_smpl_5  (pat[4]),
      .seq_smpl_6  (pat[5]),
      .seq_smpl_7  (pat[6]),
      .seq_smpl_8  (pat[7]),
      .play_idx    (play_idx),
      .play_smpl   (play_smpl),
      .play_gate   (play_gate),
      .step_strobe (step_strobe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic push(input int idx, input logic [3:0] smpl, input int period);
      exp_t e;
      e.idx    = 3'(idx);
      e.smpl   = smpl;
      e.period = period;
      exp_q.push_back(e);
   endtask

   task automatic wait_strobes(input int n);
      int seen   = 0;
      int budget = 0;
      while (seen < n && budget < 100 * n) begin
         @(negedge clk);
         budget++;
         if (step_strobe === 1'b1) seen++;
      end
      checks++;
      if (seen < n) begin
         failures++;
         $display("FAIL strobe_timeout seen=%0d expected=%0d", seen, n);
      end
   endtask

   // Monitor: every strobe pops one expected step; quiet cycles must carry no trigger.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (step_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe idx=%0d smpl=%0h", play_idx, play_smpl);
            end else begin
               e = exp_q.pop_front();
               check("sb_idx", 32'(play_idx), 32'(e.idx));
               check("sb_smpl", 32'(play_smpl), 32'(e.smpl));
               check("sb_gate", 32'(play_gate), 32'(e.smpl));
               if (e.period != 0 && last_cyc >= 0)
                  check("sb_period", 32'(cyc - last_cyc), 32'(e.period));
            end
            last_cyc = cyc;
         end else begin
            check("stray_trigger", 32'(play_smpl), 32'h0);
         end
      end
   end

   initial begin
      ref_pat = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'h3, 4'hC};
      pat     = ref_pat;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_idx", 32'(play_idx), 32'h0);
      check("rst_smpl", 32'(play_smpl), 32'h0);
      check("rst_gate", 32'(play_gate), 32'h0);
      check("rst_strobe", 32'(step_strobe), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));

      // Start: first trigger two negedges after mode rises, then a full loop at 8 cycles/step.
      tempo = 8'd2;
      mode  = MODE_PLAY;
      push(0, ref_pat[0], 0);
      for (int i = 1; i < 8; i++) push(i, ref_pat[i], 8);
      push(0, ref_pat[0], 8);
      @(negedge clk);
      check("start_fire_quiet", 32'(step_strobe), 32'h0);
      @(negedge clk);
      check("start_strobe", 32'(step_strobe), 32'h1);
      check("start_smpl", 32'(play_smpl), 32'h1);
      wait_strobes(8);

      // Tempo 0 plays as 1 tick; changes land at the following FIRE only.
      tempo = 8'd0;
      push(1, ref_pat[1], 8);
      wait_strobes(1);
      push(2, ref_pat[2], 4);
      wait_strobes(1);
      tempo = 8'd2;
      push(3, ref_pat[3], 4);
      wait_strobes(1);
      repeat (3) @(negedge clk);
      tempo = 8'd3;
      push(4, ref_pat[4], 8);
      push(5, ref_pat[5], 12);
      wait_strobes(2);
      tempo = 8'd2;
      push(6, ref_pat[6], 12);
      wait_strobes(1);

      // Pause for 5 cycles starting 3 cycles into step 6.
      push(7, ref_pat[7], 13);
      repeat (2) @(negedge clk);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("pause_gate", 32'(play_gate), 32'(ref_pat[6]));
         check("pause_idx", 32'(play_idx), 32'd6);
      end
      pause = 1'b0;
      wait_strobes(1);

      // Live edit of step 2 while it is playing.
      push(0, ref_pat[0], 8);
      push(1, ref_pat[1], 8);
      push(2, ref_pat[2], 8);
      wait_strobes(3);
      pat[2] = 4'h9;
      @(negedge clk);
      check("edit_gate_held", 32'(play_gate), 32'(ref_pat[2]));
      for (int i = 3; i < 8; i++) push(i, ref_pat[i], 8);
      push(0, ref_pat[0], 8);
      push(1, ref_pat[1], 8);
      push(2, 4'h9, 8);
      wait_strobes(8);

      // Mode exit at step 4, then restart from step 0.
      push(3, ref_pat[3], 8);
      push(4, ref_pat[4], 8);
      wait_strobes(2);
      mode = MODE_EDIT;
      @(negedge clk);
      check("stop_idx", 32'(play_idx), 32'h0);
      check("stop_smpl", 32'(play_smpl), 32'h0);
      check("stop_gate", 32'(play_gate), 32'h0);
      check("stop_strobe", 32'(step_strobe), 32'h0);
      repeat (20) @(negedge clk);
      mode = MODE_PLAY;
      push(0, ref_pat[0], 0);
      @(negedge clk);
      check("restart_fire_quiet", 32'(step_strobe), 32'h0);
      @(negedge clk);
      check("restart_strobe", 32'(step_strobe), 32'h1);
      check("restart_idx", 32'(play_idx), 32'h0);

      // Asynchronous reset between edges while waiting in step 0.
      repeat (2) @(negedge clk);
      check("pre_rst_gate", 32'(play_gate), 32'(ref_pat[0]));
      #2 rst = 1'b1;
      #1;
      check("arst_idx", 32'(play_idx), 32'h0);
      check("arst_smpl", 32'(play_smpl), 32'h0);
      check("arst_gate", 32'(play_gate), 32'h0);
      check("arst_strobe", 32'(step_strobe), 32'h0);
      check("arst_state", 32'(dut.state_q), 32'(IDLE));
      mode = MODE_EDIT;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
